// File: rtl/ysyx_22041207_decode_stage_pkg.sv
// Shared definitions for the decode stage and its consumers in EX/MEM.
// Holds opcode constants, ALU/operand/write-back codes, the packed control
// bundle dec_ctrl_t and its width CTRL_W, plus small ALU-op helpers.
package ysyx_22041207_dec_pkg;

  // Base opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU operation codes understood by EX
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  // Operand selects
  localparam logic [1:0] SEL_A_RS1  = 2'd0;
  localparam logic [1:0] SEL_A_PC   = 2'd1;
  localparam logic [1:0] SEL_A_ZERO = 2'd2;
  localparam logic [1:0] SEL_B_RS2  = 2'd0;
  localparam logic [1:0] SEL_B_IMM  = 2'd1;
  localparam logic [1:0] SEL_B_FOUR = 2'd2;

  // Write-back source
  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_CSR = 3'd3;

  // CSR operation
  localparam logic [1:0] CSR_OP_NONE = 2'd0;
  localparam logic [1:0] CSR_OP_RW   = 2'd1;
  localparam logic [1:0] CSR_OP_RS   = 2'd2;

  // Immediate format selected by the decoder
  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [7:0] wmask;
    logic       rd_wen;
    logic       mem_ren;
    logic       sext;
    logic [3:0] read_num;
    logic [2:0] wb_sel;
    logic       word_op;
    logic       rs1to32;
    logic       branch;
    logic [2:0] br_funct3;
    logic       jal;
    logic       jalr;
    logic       csr_wen;
    logic [1:0] csr_op;
    logic       ecall;
    logic       mret;
    logic       ebreak;
    logic       illegal;
  } dec_ctrl_t;

  localparam int CTRL_W = $bits(dec_ctrl_t);

  // Integer ALU op from funct3; alt selects SUB/SRA (instruction bit 30)
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Multiply/divide ALU op from funct3
  function automatic logic [4:0] alu_m(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_22041207_decode_stage_if.sv
// Handshake bundle around the decode stage.
// Upstream side: in_valid/in_ready/in_inst/in_pc.
// Downstream side: out_valid/out_ready/out_pc/out_ctrl/out_imm/out_rs1/out_rs2/out_rd.
// slave  = the decode stage's view; master = the surrounding IF/EX view.
interface ysyx_22041207_decode_stage_if #(parameter int XLEN = 64);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [31:0]                            in_inst;
  logic [XLEN-1:0]                        in_pc;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [XLEN-1:0]                        out_pc;
  logic [ysyx_22041207_dec_pkg::CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]                        out_imm;
  logic [4:0]                             out_rs1;
  logic [4:0]                             out_rs2;
  logic [4:0]                             out_rd;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_ctrl, out_imm, out_rs1, out_rs2, out_rd
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_ctrl, out_imm, out_rs1, out_rs2, out_rd
  );
endinterface

// File: rtl/ysyx_22041207_decode_stage_dec_comb.sv
// Parametrised combinational decoder and immediate generator.
// Ports: inst (32-bit instruction) in; ctrl (dec_ctrl_t), imm (XLEN,
// sign-extended; CSR address zero-extended), rs1/rs2/rd out.
// rd is forced to 0 whenever the instruction does not write a register.
module ysyx_22041207_dec_comb
  import ysyx_22041207_dec_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit HAS_M   = 1'b1,
  parameter bit HAS_CSR = 1'b1
) (
  input  logic [31:0]     inst,
  output dec_ctrl_t       ctrl,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm64;
  imm_fmt_e    fmt;
  logic        legal;
  dec_ctrl_t   raw;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  // Immediates are built at 64 bits and truncated, so RV32 needs no special case
  assign imm_i = {{52{inst[31]}}, inst[31:20]};
  assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_z = {52'b0, inst[31:20]};

  always_comb begin
    case (fmt)
      IMM_I:   imm64 = imm_i;
      IMM_S:   imm64 = imm_s;
      IMM_B:   imm64 = imm_b;
      IMM_U:   imm64 = imm_u;
      IMM_J:   imm64 = imm_j;
      IMM_Z:   imm64 = imm_z;
      default: imm64 = '0;
    endcase
  end

  assign imm = imm64[XLEN-1:0];

  // Raw decode: control fields plus a legality flag per opcode
  always_comb begin
    raw   = '0;
    fmt   = IMM_NONE;
    legal = 1'b0;
    case (opcode)
      OP_LUI: begin
        legal      = 1'b1;
        fmt        = IMM_U;
        raw.sel_a  = SEL_A_ZERO;
        raw.sel_b  = SEL_B_IMM;
        raw.rd_wen = 1'b1;
      end
      OP_AUIPC: begin
        legal      = 1'b1;
        fmt        = IMM_U;
        raw.sel_a  = SEL_A_PC;
        raw.sel_b  = SEL_B_IMM;
        raw.rd_wen = 1'b1;
      end
      OP_JAL: begin
        legal      = 1'b1;
        fmt        = IMM_J;
        raw.jal    = 1'b1;
        raw.sel_a  = SEL_A_PC;
        raw.sel_b  = SEL_B_IMM;
        raw.wb_sel = WB_PC4;
        raw.rd_wen = 1'b1;
      end
      OP_JALR: begin
        legal      = (f3 == 3'b000);
        fmt        = IMM_I;
        raw.jalr   = 1'b1;
        raw.sel_b  = SEL_B_IMM;
        raw.wb_sel = WB_PC4;
        raw.rd_wen = 1'b1;
      end
      OP_BRANCH: begin
        legal         = (f3[2:1] != 2'b01);
        fmt           = IMM_B;
        raw.branch    = 1'b1;
        raw.br_funct3 = f3;
        raw.sel_a     = SEL_A_PC;
        raw.sel_b     = SEL_B_IMM;
      end
      OP_LOAD: begin
        fmt          = IMM_I;
        raw.sel_b    = SEL_B_IMM;
        raw.mem_ren  = 1'b1;
        raw.sext     = !f3[2];
        raw.read_num = 4'd1 << f3[1:0];
        raw.wb_sel   = WB_MEM;
        raw.rd_wen   = 1'b1;
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
          3'b011, 3'b110:                         legal = IS64;
          default:                                legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        fmt       = IMM_S;
        raw.sel_b = SEL_B_IMM;
        legal     = !f3[2] && ((f3[1:0] != 2'b11) || IS64);
        case (f3[1:0])
          2'b00:   raw.wmask = 8'h01;
          2'b01:   raw.wmask = 8'h03;
          2'b10:   raw.wmask = 8'h0F;
          default: raw.wmask = 8'hFF;
        endcase
      end
      OP_IMM: begin
        fmt        = IMM_I;
        raw.sel_b  = SEL_B_IMM;
        raw.rd_wen = 1'b1;
        raw.alu_op = alu_base(f3, (f3 == 3'b101) && inst[30]);
        // RV64 shifts use a 6-bit shamt, so only inst[31:26] is funct
        case (f3)
          3'b001:  legal = IS64 ? (inst[31:26] == 6'b0) : (f7 == 7'b0);
          3'b101:  legal = IS64 ? ((inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000))
                                : ((f7 == 7'b0000000) || (f7 == 7'b0100000));
          default: legal = 1'b1;
        endcase
      end
      OP_REG: begin
        raw.rd_wen = 1'b1;
        case (f7)
          7'b0000000: begin
            legal      = 1'b1;
            raw.alu_op = alu_base(f3, 1'b0);
          end
          7'b0100000: begin
            legal      = (f3 == 3'b000) || (f3 == 3'b101);
            raw.alu_op = alu_base(f3, 1'b1);
          end
          7'b0000001: begin
            legal      = HAS_M;
            raw.alu_op = alu_m(f3);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_IMM32: begin
        fmt         = IMM_I;
        raw.sel_b   = SEL_B_IMM;
        raw.rd_wen  = 1'b1;
        raw.word_op = 1'b1;
        raw.rs1to32 = (f3 == 3'b101);
        raw.alu_op  = alu_base(f3, (f3 == 3'b101) && inst[30]);
        legal = IS64 && ((f3 == 3'b000) || ((f3 == 3'b001) && (f7 == 7'b0)) ||
                         ((f3 == 3'b101) && ((f7 == 7'b0) || (f7 == 7'b0100000))));
      end
      OP_REG32: begin
        raw.rd_wen  = 1'b1;
        raw.word_op = 1'b1;
        case (f7)
          7'b0000000: begin
            legal       = IS64 && ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101));
            raw.alu_op  = alu_base(f3, 1'b0);
            raw.rs1to32 = (f3 == 3'b101);
          end
          7'b0100000: begin
            legal       = IS64 && ((f3 == 3'b000) || (f3 == 3'b101));
            raw.alu_op  = alu_base(f3, 1'b1);
            raw.rs1to32 = (f3 == 3'b101);
          end
          7'b0000001: begin
            legal       = IS64 && HAS_M && (f3 != 3'b001) && (f3 != 3'b010) && (f3 != 3'b011);
            raw.alu_op  = alu_m(f3);
            // unsigned word divide/remainder need rs1 zero-extended from 32 bits
            raw.rs1to32 = (f3 == 3'b101) || (f3 == 3'b111);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_SYSTEM: begin
        case (f3)
          3'b000: begin
            if (inst == 32'h0010_0073) begin
              raw.ebreak = 1'b1;
              legal      = 1'b1;
            end else if (inst == 32'h0000_0073) begin
              raw.ecall = 1'b1;
              legal     = HAS_CSR;
            end else if (inst == 32'h3020_0073) begin
              raw.mret = 1'b1;
              legal    = HAS_CSR;
            end
          end
          3'b001, 3'b010: begin
            fmt         = IMM_Z;
            raw.csr_wen = 1'b1;
            raw.csr_op  = (f3 == 3'b001) ? CSR_OP_RW : CSR_OP_RS;
            raw.wb_sel  = WB_CSR;
            raw.rd_wen  = 1'b1;
            legal       = HAS_CSR;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // An illegal bundle still flows downstream but must not change any state
  always_comb begin
    ctrl         = raw;
    ctrl.illegal = !legal;
    if (!legal) begin
      ctrl.rd_wen  = 1'b0;
      ctrl.mem_ren = 1'b0;
      ctrl.wmask   = 8'h00;
      ctrl.csr_wen = 1'b0;
      ctrl.ecall   = 1'b0;
      ctrl.mret    = 1'b0;
    end
  end

  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = ctrl.rd_wen ? inst[11:7] : 5'd0;

endmodule

// File: rtl/ysyx_22041207_decode_stage.sv
// Registered, handshaked decode stage between IF and EX.
// Ports: clk, rst_n (async active-low), flush (kills all held state),
// bus (slave modport: in_* from IF, out_* to EX), halted (ebreak accepted),
// dec_count (wrapping count of accepted instructions).
// A two-entry skid buffer (E0 = output entry, E1 = skid entry) lets in_ready
// come straight from a flop.
module ysyx_22041207_decode_stage
  import ysyx_22041207_dec_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit HAS_M   = 1'b1,
  parameter bit HAS_CSR = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  ysyx_22041207_decode_stage_if.slave    bus,
  output logic                           halted,
  output logic [31:0]                    dec_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    dec_ctrl_t       ctrl;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } entry_t;

  entry_t      dec_entry;
  entry_t      e0_q, e0_n, e1_q, e1_n;
  logic        e0_valid_q, e0_valid_n;
  logic        e1_valid_q, e1_valid_n;
  logic        halted_q, halted_n;
  logic        in_ready_q, in_ready_n;
  logic [31:0] count_q, count_n;
  logic        accept;
  logic        drain;

  ysyx_22041207_dec_comb #(
    .XLEN    (XLEN),
    .HAS_M   (HAS_M),
    .HAS_CSR (HAS_CSR)
  ) u_dec (
    .inst (bus.in_inst),
    .ctrl (dec_entry.ctrl),
    .imm  (dec_entry.imm),
    .rs1  (dec_entry.rs1),
    .rs2  (dec_entry.rs2),
    .rd   (dec_entry.rd)
  );

  assign dec_entry.pc = bus.in_pc;

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = e0_valid_q && bus.out_ready;

  // Skid-buffer next state; flush overrides every other event
  always_comb begin
    e0_n       = e0_q;
    e1_n       = e1_q;
    e0_valid_n = e0_valid_q;
    e1_valid_n = e1_valid_q;
    halted_n   = halted_q;
    count_n    = count_q;
    if (flush) begin
      e0_valid_n = 1'b0;
      e1_valid_n = 1'b0;
      halted_n   = 1'b0;
    end else begin
      if (accept) begin
        count_n = count_q + 32'd1;
      end
      if (!e0_valid_q || drain) begin
        if (e1_valid_q) begin
          e0_n       = e1_q;
          e0_valid_n = 1'b1;
          e1_valid_n = accept;
          if (accept) begin
            e1_n = dec_entry;
          end
        end else begin
          e0_valid_n = accept;
          if (accept) begin
            e0_n = dec_entry;
          end
        end
      end else if (accept) begin
        e1_n       = dec_entry;
        e1_valid_n = 1'b1;
      end
      if (accept && dec_entry.ctrl.ebreak) begin
        halted_n = 1'b1;
      end
    end
    in_ready_n = !e1_valid_n && !halted_n;
  end

  // State registers; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q       <= '0;
      e1_q       <= '0;
      e0_valid_q <= 1'b0;
      e1_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      in_ready_q <= 1'b1;
      count_q    <= '0;
    end else begin
      e0_q       <= e0_n;
      e1_q       <= e1_n;
      e0_valid_q <= e0_valid_n;
      e1_valid_q <= e1_valid_n;
      halted_q   <= halted_n;
      in_ready_q <= in_ready_n;
      count_q    <= count_n;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = e0_valid_q;
  assign bus.out_pc    = e0_q.pc;
  assign bus.out_ctrl  = e0_q.ctrl;
  assign bus.out_imm   = e0_q.imm;
  assign bus.out_rs1   = e0_q.rs1;
  assign bus.out_rs2   = e0_q.rs2;
  assign bus.out_rd    = e0_q.rd;
  assign halted        = halted_q;
  assign dec_count     = count_q;

endmodule
